// File: rtl/frame_stream_rx.sv
// frame_stream_rx: magic-word hunting frame receiver with width/height header and a FWFT pixel FIFO
//   Optional trailer checksum: define FRAME_STREAM_RX_CHECKSUM_EN.
//   Ports: clk, rst (async active-high); s_data_i/s_vld_i/s_rdy_o byte input;
//   m_data_o/m_vld_o/m_rdy_i/m_sof_o/m_eol_o pixel output; width_o/height_o latched dims;
//   full_o/empty_o FIFO status; busy_o; frame_done_o/hdr_err_o/chk_err_o one-cycle pulses.
module frame_stream_rx #(
  parameter int          DATA_W     = 8,
  parameter int          DIM_BYTES  = 4,
  parameter logic [31:0] MAGIC      = 32'h4245474E,
  parameter int          FIFO_DEPTH = 16,
  parameter int          MAX_DIM    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data_i,
  input  logic                   s_vld_i,
  output logic                   s_rdy_o,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_vld_o,
  input  logic                   m_rdy_i,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [8*DIM_BYTES-1:0] width_o,
  output logic [8*DIM_BYTES-1:0] height_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   hdr_err_o,
  output logic                   chk_err_o
);
  localparam int DIM_W = 8 * DIM_BYTES;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = $clog2(DIM_BYTES + 1);
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
  typedef enum logic [2:0] {HUNT, HDR_W, HDR_H, PIX, CHK} state_t;
`else
  typedef enum logic [1:0] {HUNT, HDR_W, HDR_H, PIX} state_t;
`endif
  state_t             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [DIM_W-1:0]   wsh_q, wsh_d, hsh_q, hsh_d, wsh_nx, hsh_nx;
  logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
  logic               done_q, done_d, herr_q, herr_d;
  logic [DATA_W+1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      wp_q, rp_q;
  logic [CW-1:0]      cnt_q;
  logic               in_acc, push, pop, last_b, last_col, last_row, hdr_bad, magic_hit;
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
  logic [DATA_W-1:0]  xor_q, xor_d;
  logic               cerr_q, cerr_d;
`endif
  assign s_rdy_o   = (state_q == PIX) ? !full_o : 1'b1;
  assign in_acc    = s_vld_i && s_rdy_o;
  assign push      = in_acc && (state_q == PIX);
  assign pop       = !empty_o && m_rdy_i;
  assign full_o    = cnt_q == CW'(FIFO_DEPTH);
  assign empty_o   = cnt_q == '0;
  assign m_vld_o   = !empty_o;
  assign {m_eol_o, m_sof_o, m_data_o} = mem[rp_q];
  assign busy_o    = state_q != HUNT;
  assign width_o   = width_q;
  assign height_o  = height_q;
  assign frame_done_o = done_q;
  assign hdr_err_o = herr_q;
  // ~k selects MAGIC byte k counted from the MSB end
  assign magic_hit = s_data_i == DATA_W'(MAGIC[{~k_q, 3'b000} +: 8]);
  assign wsh_nx    = DIM_W'({wsh_q, s_data_i[7:0]});
  assign hsh_nx    = DIM_W'({hsh_q, s_data_i[7:0]});
  assign last_b    = bcnt_q == BW'(DIM_BYTES - 1);
  assign last_col  = col_q == width_q - 1'b1;
  assign last_row  = row_q == height_q - 1'b1;
  // height is checked on the value being completed by the current byte
  assign hdr_bad   = wsh_q == '0 || wsh_q > DIM_W'(MAX_DIM) || hsh_nx == '0 || hsh_nx > DIM_W'(MAX_DIM);
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bcnt_d   = bcnt_q;
    wsh_d    = wsh_q;
    hsh_d    = hsh_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    done_d   = 1'b0;
    herr_d   = 1'b0;
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
    xor_d    = xor_q;
    cerr_d   = 1'b0;
`endif
    if (in_acc) begin
      case (state_q)
        HUNT: begin
          k_d     = magic_hit ? ((k_q == 2'd3) ? 2'd0 : k_q + 2'd1) : {1'b0, s_data_i == DATA_W'(MAGIC[31:24])};
          bcnt_d  = '0;
          state_d = (magic_hit && k_q == 2'd3) ? HDR_W : HUNT;
        end
        HDR_W: begin
          wsh_d   = wsh_nx;
          bcnt_d  = last_b ? '0 : bcnt_q + 1'b1;
          state_d = last_b ? HDR_H : HDR_W;
        end
        HDR_H: begin
          hsh_d  = hsh_nx;
          bcnt_d = last_b ? '0 : bcnt_q + 1'b1;
          if (last_b) begin
            herr_d   = hdr_bad;
            state_d  = hdr_bad ? HUNT : PIX;
            width_d  = hdr_bad ? width_q : wsh_q;
            height_d = hdr_bad ? height_q : hsh_nx;
            col_d    = '0;
            row_d    = '0;
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
            xor_d    = '0;
`endif
          end
        end
        PIX: begin
          col_d = last_col ? '0 : col_q + 1'b1;
          row_d = last_col ? row_q + 1'b1 : row_q;
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
          xor_d   = xor_q ^ s_data_i;
          state_d = (last_col && last_row) ? CHK : PIX;
`else
          done_d  = last_col && last_row;
          state_d = (last_col && last_row) ? HUNT : PIX;
`endif
        end
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
        CHK: begin
          cerr_d  = s_data_i != xor_q;
          done_d  = 1'b1;
          state_d = HUNT;
        end
`endif
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      k_q      <= '0;
      bcnt_q   <= '0;
      wsh_q    <= '0;
      hsh_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
      herr_q   <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      bcnt_q   <= bcnt_d;
      wsh_q    <= wsh_d;
      hsh_q    <= hsh_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      done_q   <= done_d;
      herr_q   <= herr_d;
      wp_q     <= push ? wp_q + 1'b1 : wp_q;
      rp_q     <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= {last_col, col_q == '0 && row_q == '0, s_data_i};
  end
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q  <= '0;
      cerr_q <= 1'b0;
    end else begin
      xor_q  <= xor_d;
      cerr_q <= cerr_d;
    end
  end
  assign chk_err_o = cerr_q;
`else
  assign chk_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_frame_stream_rx.sv
// tb_frame_stream_rx: directed self-checking bench for frame_stream_rx
module tb_frame_stream_rx;
  logic        clk = 0, rst = 1;
  logic [7:0]  s_data = 0, m_data;
  logic        s_vld = 0, s_rdy, m_vld, m_rdy = 1, m_sof, m_eol;
  logic [31:0] width, height;
  logic        full, empty, busy, frame_done, hdr_err, chk_err;
  int checks = 0, errors = 0;
  int fd_cnt = 0, he_cnt = 0, ce_cnt = 0, he_run = 0, he_max = 0, hold_err = 0, full_seen = 0, stall_seen = 0;
  int rd_idx = 0;
  logic [9:0] obs [$];
  logic [9:0] hold_val;
  logic hold_pend = 0, tog_en = 0, hold_full = 0;
  frame_stream_rx dut (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_vld_i(s_vld), .s_rdy_o(s_rdy),
    .m_data_o(m_data), .m_vld_o(m_vld), .m_rdy_i(m_rdy), .m_sof_o(m_sof), .m_eol_o(m_eol),
    .width_o(width), .height_o(height), .full_o(full), .empty_o(empty), .busy_o(busy),
    .frame_done_o(frame_done), .hdr_err_o(hdr_err), .chk_err_o(chk_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (m_vld && m_rdy) obs.push_back({m_eol, m_sof, m_data});
    if (hold_pend && m_vld && {m_eol, m_sof, m_data} != hold_val) hold_err++;
    hold_pend = m_vld && !m_rdy;
    hold_val  = {m_eol, m_sof, m_data};
    if (frame_done) fd_cnt++;
    if (hdr_err) he_cnt++;
    if (chk_err) ce_cnt++;
    he_run = hdr_err ? he_run + 1 : 0;
    if (he_run > he_max) he_max = he_run;
    if (full) full_seen++;
    if (full && !s_rdy) stall_seen++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (hold_full && full) begin
      hold_full = 0;
      tog_en = 1;
    end
    if (tog_en) m_rdy = ~m_rdy;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    s_data = b;
    s_vld = 1;
    while (!s_rdy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("send_timeout", 0, 1);
    tick();
    s_vld = 0;
  endtask
  task automatic send_hdr(input logic [31:0] w, input logic [31:0] h);
    logic [31:0] m = 32'h4245474E;
    for (int i = 3; i >= 0; i--) send(m[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send(h[8*i +: 8]);
  endtask
  task automatic send_frame(input int w, input int h, input logic [7:0] base);
    logic [7:0] x = 0;
    send_hdr(w, h);
    for (int i = 0; i < w * h; i++) begin
      send(base + 8'(i));
      x ^= base + 8'(i);
    end
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
    send(x);
`endif
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (!empty && n < 500) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(tag, empty, 1);
  endtask
  task automatic check_frame(input string tag, input int w, input int h, input logic [7:0] base);
    int got_n = obs.size() - rd_idx;
    chk({tag, "_count"}, got_n, w * h);
    for (int i = 0; i < w * h && i < got_n; i++)
      chk($sformatf("%s_px%0d", tag, i), obs[rd_idx + i], {i % w == w - 1, i == 0, base + 8'(i)});
    rd_idx = obs.size();
  endtask
  initial begin
    int fd0, he0;
    logic [7:0] garbage [10] = '{8'h11, 8'h22, 8'h42, 8'h45, 8'h00, 8'h99, 8'h42, 8'hAA, 8'hBB, 8'hCC};
    logic [7:0] partial [6] = '{8'h42, 8'h45, 8'h42, 8'h45, 8'h47, 8'h4E};
    #12;
    chk("rst_flags", {m_vld, full, empty, busy, s_rdy, frame_done, hdr_err, chk_err}, 8'b0010_1000);
    chk("rst_width", width, 0);
    chk("rst_height", height, 0);
    @(negedge clk);
    rst = 0;
    tick();
    // 5x5 frame after garbage
    fd0 = fd_cnt;
    foreach (garbage[i]) send(garbage[i]);
    chk("garbage_idle", busy, 0);
    send_frame(5, 5, 8'h00);
    drain("t1_empty");
    check_frame("t1", 5, 5, 8'h00);
    chk("t1_width", width, 5);
    chk("t1_height", height, 5);
    chk("t1_done", fd_cnt - fd0, 1);
    chk("t1_busy", busy, 0);
    // backpressure burst: stall output until full, then toggle m_rdy
    m_rdy = 0;
    hold_full = 1;
    send_frame(5, 5, 8'h00);
    drain("t2_empty");
    tog_en = 0;
    m_rdy = 1;
    check_frame("t2", 5, 5, 8'h00);
    chk("t2_full_seen", full_seen > 0, 1);
    chk("t2_stall_seen", stall_seen > 0, 1);
    chk("t2_hold", hold_err, 0);
    // partial magic restart
    foreach (partial[i]) send(partial[i]);
    send(0); send(0); send(0); send(2);
    send(0); send(0); send(0); send(3);
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i));
    drain("t3_empty");
    check_frame("t3", 2, 3, 8'h30);
    chk("t3_width", width, 2);
    chk("t3_height", height, 3);
    // illegal headers
    he0 = he_cnt;
    send_hdr(0, 5);
    tick(); tick();
    chk("t4a_herr", he_cnt - he0, 1);
    chk("t4a_busy", busy, 0);
    chk("t4a_width", width, 2);
    he0 = he_cnt;
    send_hdr(3, 32'h1001);
    tick(); tick();
    chk("t4b_herr", he_cnt - he0, 1);
    chk("t4b_height", height, 3);
    chk("t4_pulse_len", he_max, 1);
    chk("t4_no_push", {empty, 8'(obs.size() - rd_idx)}, 9'h100);
    send_frame(3, 2, 8'h50);
    drain("t4_empty");
    check_frame("t4", 3, 2, 8'h50);
    // MAX_DIM accepted, then async reset with 7 bytes queued
    m_rdy = 0;
    send_hdr(4096, 1);
    chk("t5_max_busy", busy, 1);
    chk("t5_max_width", width, 4096);
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i));
    chk("t5_queued", {m_vld, empty}, 2'b10);
    #2 rst = 1;
    #1;
    chk("t5_async", {m_vld, empty, busy, s_rdy}, 4'b0101);
    chk("t5_width_rst", width, 0);
    @(negedge clk);
    rst = 0;
    m_rdy = 1;
    tick();
    rd_idx = obs.size();
    send_frame(2, 2, 8'h80);
    drain("t5_empty");
    check_frame("t5", 2, 2, 8'h80);
`ifdef FRAME_STREAM_RX_CHECKSUM_EN
    fd0 = fd_cnt;
    he0 = ce_cnt;
    send_hdr(2, 2);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    tick();
    chk("c1_no_done_yet", fd_cnt - fd0, 0);
    send(8'h0F);
    tick(); tick();
    chk("c1_done", fd_cnt - fd0, 1);
    chk("c1_cerr", ce_cnt - he0, 0);
    send_hdr(2, 2);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    send(8'h0E);
    tick(); tick();
    chk("c2_cerr", ce_cnt - he0, 1);
    drain("c_empty");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_stream_rx.md
Name: frame_stream_rx

Overview:
- Parametrised byte-stream frame receiver for the image filtering pipeline; sits between the UART/stream ingress and the filter core.
- Hunts for a configurable magic word, captures a big-endian width/height header, then forwards exactly width*height pixel bytes through an internal FIFO.
- Output is a ready/valid stream with start-of-frame and end-of-line markers.
- Generalises the single-configuration data path: parametrised data width, header size, FIFO depth and dimension limit; adds header validation and line/frame framing.

Parameters:
- DATA_W, 8, pixel/byte width in bits.
- DIM_BYTES, 4, bytes per header dimension field; DIM_W = 8*DIM_BYTES.
- MAGIC, 32'h4245474E, 4-byte start sequence, first byte in MSB ("BEGN").
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 2.
- MAX_DIM, 4096, largest legal width or height.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_data  in  DATA_W  input byte.
- s_vld  in  1  input valid.
- s_rdy  out  1  input ready.
- m_data  out  DATA_W  pixel out.
- m_vld  out  1  output valid.
- m_rdy  in  1  output ready.
- m_sof  out  1  qualifies m_data as the first pixel of a frame.
- m_eol  out  1  qualifies m_data as the last pixel of a line.
- width  out  DIM_W  latched frame width.
- height  out  DIM_W  latched frame height.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- busy  out  1  state != HUNT.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted into the FIFO.
- hdr_err  out  1  one-cycle pulse on an illegal header.
- chk_err  out  1  one-cycle pulse on checksum mismatch (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state=HUNT. All counters 0. FIFO emptied. width=height=0. m_vld=0, full=0, empty=1, busy=0, all pulses 0, s_rdy=1.
- Reset mid-frame: abandons the frame immediately; buffered pixels are discarded.
- Input beat: a byte is accepted on a clk edge with s_vld&&s_rdy. Non-accepted cycles change nothing.
- s_rdy: 1 in HUNT, HDR_W, HDR_H and CHK; !full in PIX.
- HUNT: match index k (0..3) compares the byte against MAGIC byte k.
  - Match: k+1; at k=3 -> HDR_W, k=0.
  - Mismatch: k=1 if the byte equals MAGIC byte 0, else k=0. Only this single-byte restart is supported.
- HDR_W: shift DIM_BYTES bytes MSB-first into width_shadow, then -> HDR_H.
- HDR_H: shift DIM_BYTES bytes MSB-first into height_shadow.
  - After the last byte: if either shadow is 0 or > MAX_DIM, pulse hdr_err, -> HUNT, width/height outputs unchanged.
  - Otherwise latch width/height outputs, col=row=0, -> PIX.
- PIX: each accepted byte is pushed to the FIFO with tags sof=(col==0&&row==0) and eol=(col==width-1).
  - col wraps to 0 at width-1 and row increments.
  - Acceptance at col==width-1 && row==height-1 pulses frame_done next cycle and -> HUNT (CHK when the feature is enabled).
  - Counters are DIM_W bits; no multiply is used.
- FIFO: first-word-fall-through; m_data/m_sof/m_eol come from head.
  - m_vld=!empty. Pop on m_vld&&m_rdy.
  - Latency: byte accepted at edge N is visible with m_vld=1 after edge N (one cycle) when the FIFO was empty.
  - Simultaneous push and pop: allowed at any occupancy; count unchanged.
  - Push when full: impossible, since s_rdy=0.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an occupancy counter of $clog2(FIFO_DEPTH)+1 bits.
- Frame-to-frame: the FIFO keeps draining across HUNT, so a new frame may be received while old pixels are still queued.
- m_data/m_sof/m_eol hold stable while m_vld&&!m_rdy.

Optional Feature:
- Macro FRAME_STREAM_RX_CHECKSUM_EN.
- Defined: after the last pixel -> CHK. One trailer byte is accepted and compared with the running XOR of all DATA_W-bit pixel bytes of the frame (XOR is cleared on entry to PIX). Mismatch pulses chk_err. Either way -> HUNT. frame_done pulses on trailer acceptance instead of on the last pixel.
- Undefined: no CHK state, no XOR logic, chk_err tied 0.

Test Plan:
- 10 random garbage bytes, then 42 45 47 4E, width 00 00 00 05, height 00 00 00 05, pixels 0x00..0x18, m_rdy=1 -> 25 output bytes 0x00..0x18 in order; m_sof only on 0x00; m_eol on 0x04,0x09,0x0E,0x13,0x18; width=height=5; one frame_done; busy falls.
- Same 5x5 frame as a back-to-back burst, m_rdy toggling every cycle, FIFO_DEPTH=16 -> full asserts, s_rdy drops, no byte lost or duplicated, order intact, empty=1 at end.
- Partial magic 42 45 42 45 47 4E then a valid 2x3 header -> locks on the second 42; 6 pixels forwarded; m_eol on pixels 2,4,6 (1-based).
- Header width=0, and separately height=0x1001 with MAX_DIM=4096 -> hdr_err one-cycle pulse, back to HUNT, no FIFO push; a following valid frame is received correctly.
- rst asserted asynchronously mid-PIX with 7 bytes queued -> m_vld drops without a clock edge; empty=1, state HUNT; the next full frame is received cleanly.
- With FRAME_STREAM_RX_CHECKSUM_EN: 2x2 frame 01 02 04 08, trailer 0x0F -> no chk_err, frame_done on trailer. Trailer 0x0E -> chk_err pulse.
